mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
// - Memory-access stage directly downstream of superExecute: consumes its results, serves scalar/vector loads/stores
//   against a private element-wide data memory and presents registered results for writeback.
// - Element-serial memory: scalar access = REGI_SIZE/ELEM_SIZE beats, vector = VECT_SIZE beats; stalls upstream.
// PARAMETERS
// - REGI_BITS   4    integer register index width
// - VECT_BITS   2    vector register index width
// - MEMO_LINES  64   data memory depth in elements; addresses wrap modulo MEMO_LINES
// - REGI_SIZE   16   scalar data width
// - VECT_SIZE   8    elements per vector
// - ELEM_SIZE   8    element width = memory word width
// PORTS
// - clk_i          in   1                    clock, all state on rising edge
// - rst_i          in   1                    reset: synchronous, active-high
// - valid_i        in   1                    execute result present this cycle
// - enableMem      in   1                    op is a memory access
// - flagMemRead    in   1                    load
// - flagMemWrite   in   1                    store
// - vec_i          in   1                    1 = vector access/vector result, 0 = scalar
// - addr_i         in   REGI_SIZE            element address (ialu_res_o)
// - int_data_i     in   REGI_SIZE            scalar store data / non-mem scalar result
// - vec_data_i     in   ELEM_SIZE*VECT_SIZE  vector store data / non-mem vector result
// - int_rd_i       in   REGI_BITS            scalar destination index
// - vec_rd_i       in   VECT_BITS            vector destination index
// - stall_o        out  1                    upstream must hold its current op
// - valid_o        out  1                    result registered, one-cycle pulse per op
// - int_we_o       out  1                    write int_res_o to int_rd_o
// - vec_we_o       out  1                    write vec_res_o to vec_rd_o
// - int_res_o      out  REGI_SIZE            scalar result
// - vec_res_o      out  ELEM_SIZE*VECT_SIZE  vector result
// - int_rd_o       out  REGI_BITS            registered scalar dest
// - vec_rd_o       out  VECT_BITS            registered vector dest
// BEHAVIOUR
// - Reset: state IDLE, beat=0; valid_o, int_we_o, vec_we_o, stall_o = 0; int_res_o, vec_res_o, int_rd_o, vec_rd_o = 0.
//   Memory contents NOT cleared. Reset mid-access aborts: elements already stored stay written, no valid_o.
// - FSM IDLE/ACCESS. N = vec_i ? VECT_SIZE : REGI_SIZE/ELEM_SIZE (always >= 2).
// - Non-mem op (valid_i & ~enableMem) in IDLE: latency 1; next cycle valid_o=1, data/dest copied,
//   int_we_o=~vec_i, vec_we_o=vec_i. stall_o=0.
// - Mem op in IDLE: beat 0 performed same cycle; op fields captured; -> ACCESS, beat=1.
// - ACCESS: beat k each cycle; element k at (addr+k) mod MEMO_LINES; data bits [k*ELEM_SIZE +: ELEM_SIZE] (little-endian).
//   Last beat (k=N-1): -> IDLE; next cycle valid_o=1. Load: assembled word in int_res_o/vec_res_o, matching we=1.
//   Store: valid_o=1, both we=0.
// - stall_o (comb) = (IDLE & valid_i & enableMem) | (ACCESS & beat!=N-1). Low on last beat so upstream advances;
//   inputs held on that cycle are ignored (already captured). Occupancy N cycles; result at cycle N.
// - Inputs ignored in ACCESS. valid_i=0 in IDLE: valid_o=0, we=0, data outputs hold last value.
// - flagMemRead & flagMemWrite both set: store performed, no writeback. enableMem with neither flag: treated as non-mem.
// - Read async within memory, write on clock edge; a load beat reading an address stored earlier in-flight sees new data.
// STRUCTURE
// - Package mem_stage_pkg: typedef enum {IDLE, ACCESS} mem_state_t; localparams SCAL_BEATS, VECT_BEATS, beat counter width.
// - Sub-module data_mem_elem: MEMO_LINES x ELEM_SIZE single-port RAM, async read, sync write, no reset.
// - Top: FSM, beat counter, op capture regs, load assembly shift-in, output regs.
// TESTING
// - Reset 5 cycles, release -> all outputs 0; held non-mem valid_i keeps stall_o=0.
// - Non-mem scalar int_data_i=16'hBEEF, int_rd_i=3 -> next cycle valid_o=1, int_we_o=1, int_res_o=16'hBEEF, int_rd_o=3.
// - Scalar store 16'hA55A @ addr 10, then scalar load @ 10 -> stall_o high 1 cycle each; load int_res_o=16'hA55A at cycle 2.
// - Vector store 64'h0706050403020100 @ addr 60, vector load @ 60 -> wraps to 0..3; vec_res_o=64'h0706050403020100 at cycle 8.
// - Back-to-back mem ops: second op accepted cycle after first's last beat, no lost/duplicated op; valid_o pulses once each.
// - rst_i asserted at beat 4 of vector store -> valid_o stays 0, elements 0..3 written, 4..7 unchanged, FSM IDLE next cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// Beat counts assume the default REGI_SIZE/ELEM_SIZE/VECT_SIZE geometry.
package mem_stage_pkg;

    typedef enum logic {IDLE, ACCESS} mem_state_t;

    localparam int SCAL_BEATS = 16 / 8;
    localparam int VECT_BEATS = 8;
    localparam int BEAT_W     = $clog2(VECT_BEATS);

    function automatic logic [BEAT_W-1:0] last_beat(input logic is_vec);
        return is_vec ? BEAT_W'(VECT_BEATS - 1) : BEAT_W'(SCAL_BEATS - 1);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-to-memory-stage bundle: op fields from execute, stall and writeback results back.
interface mem_stage_if #(
    parameter int REGI_BITS = 4,
    parameter int VECT_BITS = 2,
    parameter int REGI_SIZE = 16,
    parameter int VECT_SIZE = 8,
    parameter int ELEM_SIZE = 8
);
    localparam int VW = ELEM_SIZE * VECT_SIZE;

    logic                 valid_i;
    logic                 enableMem;
    logic                 flagMemRead;
    logic                 flagMemWrite;
    logic                 vec_i;
    logic [REGI_SIZE-1:0] addr_i;
    logic [REGI_SIZE-1:0] int_data_i;
    logic [VW-1:0]        vec_data_i;
    logic [REGI_BITS-1:0] int_rd_i;
    logic [VECT_BITS-1:0] vec_rd_i;

    logic                 stall_o;
    logic                 valid_o;
    logic                 int_we_o;
    logic                 vec_we_o;
    logic [REGI_SIZE-1:0] int_res_o;
    logic [VW-1:0]        vec_res_o;
    logic [REGI_BITS-1:0] int_rd_o;
    logic [VECT_BITS-1:0] vec_rd_o;

    modport slave (
        input  valid_i, enableMem, flagMemRead, flagMemWrite, vec_i,
               addr_i, int_data_i, vec_data_i, int_rd_i, vec_rd_i,
        output stall_o, valid_o, int_we_o, vec_we_o,
               int_res_o, vec_res_o, int_rd_o, vec_rd_o
    );

    modport master (
        output valid_i, enableMem, flagMemRead, flagMemWrite, vec_i,
               addr_i, int_data_i, vec_data_i, int_rd_i, vec_rd_i,
        input  stall_o, valid_o, int_we_o, vec_we_o,
               int_res_o, vec_res_o, int_rd_o, vec_rd_o
    );

endinterface

// File: rtl/mem_stage_data_mem_elem.sv
// Element-wide single-port data RAM: asynchronous read, write on the rising edge, no reset.
module data_mem_elem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: element-serial scalar/vector loads and stores against a private RAM,
// non-memory results passed through with one cycle of latency.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int REGI_BITS  = 4,
    parameter int VECT_BITS  = 2,
    parameter int MEMO_LINES = 64,
    parameter int REGI_SIZE  = 16,
    parameter int VECT_SIZE  = 8,
    parameter int ELEM_SIZE  = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    mem_stage_if.slave bus
);

    localparam int VW = ELEM_SIZE * VECT_SIZE;
    localparam int AW = $clog2(MEMO_LINES);

    function automatic logic [AW-1:0] wrap_addr(input logic [31:0] a);
        return AW'(a % MEMO_LINES);
    endfunction

    mem_state_t           state_q;
    logic [BEAT_W-1:0]    beat_q;
    logic                 vec_q;
    logic                 load_q;
    logic                 store_q;
    logic [AW-1:0]        addr_q;
    logic [VW-1:0]        wdata_q;
    logic [VW-1:0]        ldbuf_q;
    logic [REGI_BITS-1:0] op_int_rd_q;
    logic [VECT_BITS-1:0] op_vec_rd_q;

    logic                 valid_q;
    logic                 int_we_q;
    logic                 vec_we_q;
    logic [REGI_SIZE-1:0] int_res_q;
    logic [VW-1:0]        vec_res_q;
    logic [REGI_BITS-1:0] int_rd_q;
    logic [VECT_BITS-1:0] vec_rd_q;

    logic                 in_idle;
    logic                 mem_op;
    logic                 start;
    logic                 last;
    logic [VW-1:0]        new_wdata;
    logic [AW-1:0]        mem_addr;
    logic [ELEM_SIZE-1:0] mem_wdata;
    logic [ELEM_SIZE-1:0] mem_rdata;
    logic                 mem_we;
    logic [VW-1:0]        ld_next;

    // An op with enableMem but no read/write flag is handled as a non-memory op.
    assign mem_op    = bus.valid_i & bus.enableMem & (bus.flagMemRead | bus.flagMemWrite);
    assign in_idle   = (state_q == IDLE);
    assign start     = in_idle & mem_op;
    assign last      = !in_idle && (beat_q == last_beat(vec_q));
    assign new_wdata = bus.vec_i ? bus.vec_data_i : VW'(bus.int_data_i);

    assign mem_addr  = in_idle ? wrap_addr(32'(bus.addr_i))
                               : wrap_addr(32'(addr_q) + 32'(beat_q));
    assign mem_wdata = in_idle ? new_wdata[ELEM_SIZE-1:0]
                               : wdata_q[int'(beat_q)*ELEM_SIZE +: ELEM_SIZE];
    // Reset suppresses the write so an aborted access stops at the beat before reset.
    assign mem_we    = !rst_i && (in_idle ? (start & bus.flagMemWrite) : store_q);

    // Elements shift in from the top, so element k ends at bits [k*ELEM_SIZE +: ELEM_SIZE].
    assign ld_next   = {mem_rdata, ldbuf_q[VW-1:ELEM_SIZE]};

    data_mem_elem #(
        .DEPTH (MEMO_LINES),
        .WIDTH (ELEM_SIZE),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            valid_q   <= 1'b0;
            int_we_q  <= 1'b0;
            vec_we_q  <= 1'b0;
            int_res_q <= '0;
            vec_res_q <= '0;
            int_rd_q  <= '0;
            vec_rd_q  <= '0;
        end else begin
            valid_q  <= 1'b0;
            int_we_q <= 1'b0;
            vec_we_q <= 1'b0;
            if (in_idle) begin
                if (start) begin
                    state_q     <= ACCESS;
                    beat_q      <= BEAT_W'(1);
                    vec_q       <= bus.vec_i;
                    store_q     <= bus.flagMemWrite;
                    load_q      <= bus.flagMemRead & ~bus.flagMemWrite;
                    addr_q      <= wrap_addr(32'(bus.addr_i));
                    wdata_q     <= new_wdata;
                    op_int_rd_q <= bus.int_rd_i;
                    op_vec_rd_q <= bus.vec_rd_i;
                    ldbuf_q     <= ld_next;
                end else if (bus.valid_i) begin
                    valid_q <= 1'b1;
                    if (bus.vec_i) begin
                        vec_we_q  <= 1'b1;
                        vec_res_q <= bus.vec_data_i;
                        vec_rd_q  <= bus.vec_rd_i;
                    end else begin
                        int_we_q  <= 1'b1;
                        int_res_q <= bus.int_data_i;
                        int_rd_q  <= bus.int_rd_i;
                    end
                end
            end else begin
                ldbuf_q <= ld_next;
                beat_q  <= beat_q + BEAT_W'(1);
                if (last) begin
                    state_q <= IDLE;
                    beat_q  <= '0;
                    valid_q <= 1'b1;
                    if (load_q && vec_q) begin
                        vec_we_q  <= 1'b1;
                        vec_res_q <= ld_next;
                        vec_rd_q  <= op_vec_rd_q;
                    end else if (load_q) begin
                        int_we_q  <= 1'b1;
                        int_res_q <= ld_next[VW-1 -: REGI_SIZE];
                        int_rd_q  <= op_int_rd_q;
                    end
                end
            end
        end
    end

    assign bus.stall_o   = start | (!in_idle & !last);
    assign bus.valid_o   = valid_q;
    assign bus.int_we_o  = int_we_q;
    assign bus.vec_we_o  = vec_we_q;
    assign bus.int_res_o = int_res_q;
    assign bus.vec_res_o = vec_res_q;
    assign bus.int_rd_o  = int_rd_q;
    assign bus.vec_rd_o  = vec_rd_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: randomized op stream, array-based memory model, in-order scoreboard.
module tb_mem_stage;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_stage_if bus ();

    mem_stage dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic        int_we;
        logic        vec_we;
        logic [15:0] ires;
        logic [63:0] vres;
        logic [3:0]  ird;
        logic [1:0]  vrd;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [7:0]  ref_mem [64];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.valid_o) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: valid_o=1 with no op outstanding (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("latency", 64'(cyc), 64'(mon_e.due));
                chk("int_we", 64'(bus.int_we_o), 64'(mon_e.int_we));
                chk("vec_we", 64'(bus.vec_we_o), 64'(mon_e.vec_we));
                if (mon_e.int_we) begin
                    chk("int_res", 64'(bus.int_res_o), 64'(mon_e.ires));
                    chk("int_rd", 64'(bus.int_rd_o), 64'(mon_e.ird));
                end
                if (mon_e.vec_we) begin
                    chk("vec_res", bus.vec_res_o, mon_e.vres);
                    chk("vec_rd", 64'(bus.vec_rd_o), 64'(mon_e.vrd));
                end
            end
        end
    end

    task automatic set_idle();
        bus.valid_i      = 1'b0;
        bus.enableMem    = 1'b0;
        bus.flagMemRead  = 1'b0;
        bus.flagMemWrite = 1'b0;
        bus.vec_i        = 1'b0;
        bus.addr_i       = '0;
        bus.int_data_i   = '0;
        bus.vec_data_i   = '0;
        bus.int_rd_i     = '0;
        bus.vec_rd_i     = '0;
    endtask

    // Called just after a falling edge; returns just after the falling edge that follows acceptance.
    task automatic issue(input bit vld, input bit en, input bit rd, input bit wr, input bit vec,
                         input logic [15:0] addr, input logic [15:0] idata,
                         input logic [63:0] vdata, input logic [3:0] ird, input logic [1:0] vrd);
        bit          memop;
        int          n;
        int          cycles;
        logic        s;
        logic [63:0] sdata;
        exp_t        e;
        bus.valid_i      = vld;
        bus.enableMem    = en;
        bus.flagMemRead  = rd;
        bus.flagMemWrite = wr;
        bus.vec_i        = vec;
        bus.addr_i       = addr;
        bus.int_data_i   = idata;
        bus.vec_data_i   = vdata;
        bus.int_rd_i     = ird;
        bus.vec_rd_i     = vrd;
        memop = vld && en && (rd || wr);
        n     = memop ? (vec ? 8 : 2) : 1;
        sdata = vec ? vdata : {48'h0, idata};
        e = '{due: cyc + n, int_we: 1'b0, vec_we: 1'b0, ires: '0, vres: '0, ird: ird, vrd: vrd};
        if (memop && wr) begin
            for (int k = 0; k < n; k++) ref_mem[(int'(addr) + k) % 64] = sdata[k*8 +: 8];
        end else if (memop) begin
            for (int k = 0; k < n; k++) e.vres[k*8 +: 8] = ref_mem[(int'(addr) + k) % 64];
            e.ires   = e.vres[15:0];
            e.int_we = !vec;
            e.vec_we = vec;
        end else begin
            e.ires   = idata;
            e.vres   = vdata;
            e.int_we = !vec;
            e.vec_we = vec;
        end
        if (vld) sb.push_back(e);
        cycles = 0;
        do begin
            #1;
            s = bus.stall_o;
            @(negedge clk);
            cycles++;
        end while (s && cycles < 20);
        if (vld) chk("occupancy", 64'(cycles), 64'(n));
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] rv;
        logic [15:0] ra;
        int          kind;
        rst = 1'b1;
        set_idle();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid_o", 64'(bus.valid_o), 0);
        chk("rst_int_we_o", 64'(bus.int_we_o), 0);
        chk("rst_vec_we_o", 64'(bus.vec_we_o), 0);
        chk("rst_stall_o", 64'(bus.stall_o), 0);
        chk("rst_int_res_o", 64'(bus.int_res_o), 0);
        chk("rst_vec_res_o", bus.vec_res_o, 0);
        chk("rst_int_rd_o", 64'(bus.int_rd_o), 0);
        chk("rst_vec_rd_o", 64'(bus.vec_rd_o), 0);
        @(negedge clk);

        // Held non-memory ops never stall.
        for (int i = 0; i < 3; i++)
            issue(1, 0, 0, 0, i[0], 16'(i), 16'(i * 7), 64'(i * 13), 4'(i), 2'(i));
        issue(1, 0, 0, 0, 0, 16'h0, 16'hBEEF, 64'h0, 4'd3, 2'd0);

        // Give every memory element a known value.
        for (int i = 0; i < 8; i++)
            issue(1, 1, 0, 1, 1, 16'(i * 8), 16'h0, {$urandom, $urandom}, 4'd0, 2'd0);

        issue(1, 1, 0, 1, 0, 16'd10, 16'hA55A, 64'h0, 4'd1, 2'd0);
        issue(1, 1, 1, 0, 0, 16'd10, 16'h0, 64'h0, 4'd5, 2'd0);
        issue(1, 1, 0, 1, 1, 16'd60, 16'h0, 64'h0706050403020100, 4'd0, 2'd2);
        issue(1, 1, 1, 0, 1, 16'd60, 16'h0, 64'h0, 4'd0, 2'd3);
        issue(0, 0, 0, 0, 0, 16'd0, 16'h0, 64'h0, 4'd0, 2'd0);
        chk("sbox_a55a", 64'({ref_mem[11], ref_mem[10]}), 64'hA55A);

        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 8));
            rv   = {$urandom, $urandom};
            ra   = 16'($urandom);
            case (kind)
                0: issue(1, 0, 0, 0, 0, ra, rv[15:0], rv, 4'($urandom), 2'($urandom));
                1: issue(1, 0, 0, 0, 1, ra, rv[15:0], rv, 4'($urandom), 2'($urandom));
                2: issue(1, 1, 1, 0, 0, ra, rv[15:0], rv, 4'($urandom), 2'($urandom));
                3: issue(1, 1, 1, 0, 1, ra, rv[15:0], rv, 4'($urandom), 2'($urandom));
                4: issue(1, 1, 0, 1, 0, ra, rv[15:0], rv, 4'($urandom), 2'($urandom));
                5: issue(1, 1, 0, 1, 1, ra, rv[15:0], rv, 4'($urandom), 2'($urandom));
                6: issue(1, 1, 1, 1, rv[0], ra, rv[15:0], rv, 4'($urandom), 2'($urandom));
                7: issue(1, 1, 0, 0, rv[1], ra, rv[15:0], rv, 4'($urandom), 2'($urandom));
                default: issue(0, 1, 1, 0, 1, ra, rv[15:0], rv, 4'd0, 2'd0);
            endcase
        end
        set_idle();
        @(negedge clk);

        // Vector store to 20..27 aborted by reset while beat 4 is pending.
        rv = 64'hF7E6D5C4B3A29180;
        bus.valid_i      = 1'b1;
        bus.enableMem    = 1'b1;
        bus.flagMemWrite = 1'b1;
        bus.vec_i        = 1'b1;
        bus.addr_i       = 16'd20;
        bus.vec_data_i   = rv;
        repeat (4) @(negedge clk);
        #1;
        chk("abort_stall_mid", 64'(bus.stall_o), 1);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) ref_mem[20 + k] = rv[k*8 +: 8];
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        #1;
        chk("abort_valid_o", 64'(bus.valid_o), 0);
        chk("abort_idle_stall", 64'(bus.stall_o), 0);
        @(negedge clk);
        issue(1, 1, 1, 0, 1, 16'd20, 16'h0, 64'h0, 4'd0, 2'd1);
        issue(1, 1, 1, 0, 0, 16'd22, 16'h0, 64'h0, 4'd9, 2'd0);
        issue(1, 1, 1, 0, 0, 16'd24, 16'h0, 64'h0, 4'd10, 2'd0);
        set_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
